// File: rtl/vend_credit_engine.sv
// Vending credit engine: price accumulation, coin credit, dispense handshake
// and change/refund payout as a train of coin pulses.
module vend_credit_engine #(
    parameter int WIDTH       = 8,
    parameter int SEL_W       = 3,
    parameter logic [(2**SEL_W)*WIDTH-1:0] VAL_TABLE =
        {8'd40, 8'd35, 8'd30, 8'd25, 8'd15, 8'd10, 8'd5, 8'd0},
    parameter int CHG_COIN    = 5,
    parameter int TIMEOUT_CYC = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] sel,
    input  logic             price_add,
    input  logic             price_lock,
    input  logic             coin_in,
    input  logic             cancel,
    input  logic             disp_ack,
    output logic [WIDTH-1:0] price,
    output logic [WIDTH-1:0] credit,
    output logic             dispense,
    output logic             change_pulse,
    output logic             busy,
    output logic             ovf,
    output logic [2:0]       disp_code
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [WIDTH-1:0] COIN_V   = WIDTH'(CHG_COIN);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    // State encodings double as the display message codes.
    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        PRICE    = 3'b010,
        COLLECT  = 3'b100,
        DISPENSE = 3'b101,
        CHANGE   = 3'b011
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             pay_gap;

    logic [WIDTH-1:0] sel_val;
    logic [WIDTH:0]   price_sum;
    logic [WIDTH:0]   credit_sum;
    logic [WIDTH-1:0] price_next;
    logic [WIDTH-1:0] credit_next;
    logic             price_sat;
    logic             credit_sat;
    logic [WIDTH-1:0] remainder;

    // Unsigned add clamped at all-ones; the MSB of the result flags saturation.
    function automatic logic [WIDTH:0] sat_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[WIDTH]) begin
            return {1'b1, {WIDTH{1'b1}}};
        end else begin
            return s;
        end
    endfunction

    // Table lookup and the candidate price/credit values for this cycle.
    always_comb begin
        sel_val    = VAL_TABLE[int'(sel) * WIDTH +: WIDTH];
        price_sum  = sat_add(price, sel_val);
        credit_sum = sat_add(credit, sel_val);
        remainder  = credit - price;
        if (price_add) begin
            price_next = price_sum[WIDTH-1:0];
            price_sat  = price_sum[WIDTH];
        end else begin
            price_next = price;
            price_sat  = 1'b0;
        end
        if (coin_in) begin
            credit_next = credit_sum[WIDTH-1:0];
            credit_sat  = credit_sum[WIDTH];
        end else begin
            credit_next = credit;
            credit_sat  = 1'b0;
        end
    end

    // Control FSM with its registered datapath and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            price        <= '0;
            credit       <= '0;
            dispense     <= 1'b0;
            change_pulse <= 1'b0;
            ovf          <= 1'b0;
            timer        <= '0;
            pay_gap      <= 1'b0;
        end else begin
            change_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (price_add) begin
                        price  <= sel_val;
                        credit <= '0;
                        ovf    <= 1'b0;
                        state  <= PRICE;
                    end
                end
                PRICE: begin
                    if (cancel) begin
                        price <= '0;
                        state <= IDLE;
                    end else begin
                        price <= price_next;
                        ovf   <= ovf | price_sat;
                        if (price_lock && (price_next != '0)) begin
                            timer <= '0;
                            state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    credit <= credit_next;
                    ovf    <= ovf | credit_sat;
                    // A simultaneous coin is already folded into credit_next, so cancel refunds it.
                    if (cancel) begin
                        pay_gap <= 1'b0;
                        state   <= CHANGE;
                    end else if (coin_in && (credit_next >= price)) begin
                        dispense <= 1'b1;
                        state    <= DISPENSE;
                    end else if (coin_in) begin
                        timer <= '0;
                    end else if (timer == TMR_LAST) begin
                        pay_gap <= 1'b0;
                        state   <= CHANGE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                DISPENSE: begin
                    if (disp_ack) begin
                        credit   <= remainder;
                        price    <= '0;
                        dispense <= 1'b0;
                        if (remainder >= COIN_V) begin
                            pay_gap <= 1'b0;
                            state   <= CHANGE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                CHANGE: begin
                    if (pay_gap) begin
                        pay_gap <= 1'b0;
                    end else if (credit >= COIN_V) begin
                        change_pulse <= 1'b1;
                        credit       <= credit - COIN_V;
                        pay_gap      <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    dispense <= 1'b0;
                    pay_gap  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign disp_code = state;

endmodule
